// File: rtl/cram_rd_arbiter.sv
// Two-requester round-robin read arbiter in front of a single CRAM AXI4 read port.
// Tracks outstanding reads per requester and silently drains fetch reads on flush.
module cram_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              flush0,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [31:0]       s_araddr,
    output logic [3:0]        s_arid,
    output logic [7:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic              s_arlock,
    output logic [3:0]        s_arcache,
    output logic [2:0]        s_arprot,
    output logic [3:0]        s_arqos,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [3:0]        s_rid,
    input  logic [31:0]       s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam logic [2:0] MAX = 3'(MAX_OUT);

    state_t      state_q;
    logic        rr_q;
    logic        arvalid_q;
    logic        arid_q;
    logic [31:0] araddr_q;
    logic [2:0]  out0_q, out0_d;
    logic [2:0]  out1_q, out1_d;
    logic [2:0]  drop0_q, drop0_d;

    logic        el0, el1, grant, win;
    logic        id_ok, dropping0, to0, to1;
    logic        beat0, beat1, rdy;
    logic        unused_ok;

    assign el0 = (state_q == IDLE) & m0_arvalid & (out0_q < MAX)
               & ~flush0 & ~nrst;
    assign el1 = (state_q == IDLE) & m1_arvalid & (out1_q < MAX) & ~nrst;
    assign grant = el0 | el1;
    assign win   = (el0 & el1) ? rr_q : el1;

    assign m0_arready = grant & ~win;
    assign m1_arready = grant & win;

    // Flush-cycle id-0 beats belong to the squashed stream as well.
    assign id_ok     = (s_rid[3:1] == 3'b000);
    assign dropping0 = flush0 | (drop0_q != 3'd0);
    assign to0       = s_rvalid & id_ok & ~s_rid[0];
    assign to1       = s_rvalid & id_ok & s_rid[0];

    assign m0_rvalid = to0 & ~dropping0 & ~nrst;
    assign m1_rvalid = to1 & ~nrst;
    assign m0_rdata  = DATA_W'(s_rdata);
    assign m1_rdata  = DATA_W'(s_rdata);
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;

    always_comb begin
        rdy = 1'b0;
        if (!nrst) begin
            if (!id_ok)
                rdy = 1'b1;
            else if (s_rid[0])
                rdy = m1_rready;
            else
                rdy = dropping0 | m0_rready;
        end
    end
    assign s_rready = rdy;

    assign beat0 = to0 & rdy;
    assign beat1 = to1 & rdy;

    function automatic logic [2:0] cnt_next(
        input logic [2:0] c,
        input logic       inc,
        input logic       dec
    );
        logic [2:0] r;
        r = c;
        unique case ({inc, dec && (c != 3'd0)})
            2'b10:   r = c + 3'd1;
            2'b01:   r = c - 3'd1;
            default: r = c;
        endcase
        return r;
    endfunction

    always_comb begin
        out0_d  = cnt_next(out0_q, m0_arready, beat0);
        out1_d  = cnt_next(out1_q, m1_arready, beat1);
        drop0_d = drop0_q;
        if (flush0)
            drop0_d = (beat0 && out0_q != 3'd0) ? out0_q - 3'd1 : out0_q;
        else if (beat0 && drop0_q != 3'd0)
            drop0_d = drop0_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            arvalid_q <= 1'b0;
            arid_q    <= 1'b0;
            araddr_q  <= 32'd0;
            out0_q    <= 3'd0;
            out1_q    <= 3'd0;
            drop0_q   <= 3'd0;
        end else begin
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            drop0_q <= drop0_d;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q   <= ISSUE;
                        arvalid_q <= 1'b1;
                        arid_q    <= win;
                        araddr_q  <= win ? 32'(m1_araddr) : 32'(m0_araddr);
                        rr_q      <= ~win;
                    end
                end
                ISSUE: begin
                    if (s_arready) begin
                        state_q   <= IDLE;
                        arvalid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_arvalid = arvalid_q;
    assign s_araddr  = araddr_q;
    assign s_arid    = {3'b000, arid_q};
    assign s_arlen   = 8'd0;
    assign s_arsize  = 3'd2;
    assign s_arburst = 2'd1;
    assign s_arlock  = 1'b0;
    assign s_arcache = 4'd0;
    assign s_arprot  = 3'd0;
    assign s_arqos   = 4'd0;

    assign unused_ok = s_rlast;

endmodule

// File: tb/tb_cram_rd_arbiter.sv
// Directed scoreboard bench for cram_rd_arbiter: grant order, backpressure,
// outstanding limit, fetch flush drain and mid-issue reset.
module tb_cram_rd_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        flush0;
    logic        m0_arvalid, m1_arvalid;
    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arready, m1_arready;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic        m0_rready, m1_rready;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic [3:0]  s_arid;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arlock;
    logic [3:0]  s_arcache;
    logic [2:0]  s_arprot;
    logic [3:0]  s_arqos;
    logic        s_rvalid, s_rready;
    logic [3:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
    } ar_t;

    ar_t         arq[$];
    logic [31:0] rq[$];
    int          tests = 0;
    int          fails = 0;

    cram_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
        .clk(clk), .nrst(nrst), .flush0(flush0),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr),
        .m1_arready(m1_arready), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
        .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nrst       = 1'b1;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        flush0     = 1'b0;
        s_rvalid   = 1'b0;
        tick();
        tick();
        nrst = 1'b0;
    endtask

    // Wait (bounded) for the next AR beat and compare against the queue head.
    task automatic wait_ar(input string tag);
        ar_t e;
        int  n;
        n = 0;
        while (s_arvalid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(s_arvalid), 64'd1);
        if (arq.size() == 0) begin
            chk({tag, "_q"}, 64'(arq.size()), 64'd1);
        end else begin
            e = arq.pop_front();
            chk({tag, "_addr"}, 64'(s_araddr), 64'(e.addr));
            chk({tag, "_id"}, 64'(s_arid), 64'(e.id));
        end
        tick();
    endtask

    initial begin
        int g;
        nrst = 1'b1;
        flush0 = 1'b0;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_araddr = '0; m1_araddr = '0;
        m0_rready = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0;
        s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'h1234; s_rresp = 2'd0;
        s_rlast = 1'b1;
        m0_arvalid = 1'b1;
        tick();
        tick();
        chk("rst_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_araddr", 64'(s_araddr), 64'd0);
        chk("rst_arid", 64'(s_arid), 64'd0);
        chk("rst_m0_arready", 64'(m0_arready), 64'd0);
        chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("rst_out0", 64'(dut.out0_q), 64'd0);
        chk("arsize", 64'(s_arsize), 64'd2);
        chk("arburst", 64'(s_arburst), 64'd1);
        do_reset();

        // single fetch
        s_arready  = 1'b1;
        m0_arvalid = 1'b1;
        m0_araddr  = 32'h40;
        #1;
        chk("sf_grant", 64'(m0_arready), 64'd1);
        arq.push_back('{addr: 32'h40, id: 4'd0});
        tick();
        m0_arvalid = 1'b0;
        chk("sf_latency", 64'(s_arvalid), 64'd1);
        wait_ar("sf_ar");
        chk("sf_out0_busy", 64'(dut.out0_q), 64'd1);
        s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'hDEADBEEF;
        m0_rready = 1'b1;
        rq.push_back(32'hDEADBEEF);
        #1;
        chk("sf_rvalid", 64'(m0_rvalid), 64'd1);
        chk("sf_rdata", 64'(m0_rdata), 64'(rq.pop_front()));
        chk("sf_rready", 64'(s_rready), 64'd1);
        tick();
        s_rvalid = 1'b0;
        chk("sf_out0_done", 64'(dut.out0_q), 64'd0);

        // contention
        do_reset();
        m0_araddr = 32'h100; m1_araddr = 32'h200;
        for (int i = 0; i < 2; i++) begin
            arq.push_back('{addr: 32'h100, id: 4'd0});
            arq.push_back('{addr: 32'h200, id: 4'd1});
        end
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        for (int i = 0; i < 4; i++) wait_ar($sformatf("rr%0d", i));
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;

        // backpressure
        do_reset();
        s_arready  = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h300;
        #1;
        chk("bp_grant", 64'(m1_arready), 64'd1);
        arq.push_back('{addr: 32'h300, id: 4'd1});
        tick();
        m0_arvalid = 1'b1; m0_araddr = 32'h304;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 64'(s_arvalid), 64'd1);
            chk("bp_addr", 64'(s_araddr), 64'(arq[0].addr));
            chk("bp_id", 64'(s_arid), 64'(arq[0].id));
            chk("bp_nogrant", 64'({m0_arready, m1_arready}), 64'd0);
            tick();
        end
        void'(arq.pop_front());
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        s_arready = 1'b1;
        tick();
        chk("bp_release", 64'(s_arvalid), 64'd0);

        // outstanding limit
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'h80;
        g = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (m0_arready === 1'b1) g++;
            tick();
        end
        chk("lim_grants", 64'(g), 64'd4);
        chk("lim_out0", 64'(dut.out0_q), 64'd4);
        chk("lim_stall", 64'(m0_arready), 64'd0);
        s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'hA5; m0_rready = 1'b1;
        #1;
        chk("lim_rvalid", 64'(m0_rvalid), 64'd1);
        tick();
        s_rvalid = 1'b0;
        #1;
        chk("lim_reenable", 64'(m0_arready), 64'd1);
        m0_arvalid = 1'b0;

        // flush drain
        do_reset();
        m0_arvalid = 1'b1; m0_araddr = 32'hC0;
        g = 0;
        #1;
        for (int i = 0; i < 20 && g < 3; i++) begin
            if (m0_arready === 1'b1) g++;
            tick();
        end
        m0_arvalid = 1'b0;
        tick();
        chk("fl_out0", 64'(dut.out0_q), 64'd3);
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        chk("fl_drop_load", 64'(dut.drop0_q), 64'd3);
        m0_rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_rvalid = 1'b1; s_rid = 4'd0; s_rdata = 32'hBAD0 + 32'(i);
            #1;
            chk("fl_m0_quiet", 64'(m0_rvalid), 64'd0);
            chk("fl_rready", 64'(s_rready), 64'd1);
            tick();
            chk("fl_drop", 64'(dut.drop0_q), 64'(2 - i));
        end
        s_rid = 4'd1; s_rdata = 32'h1111; m1_rready = 1'b1;
        rq.push_back(32'h1111);
        #1;
        chk("fl_m1_rvalid", 64'(m1_rvalid), 64'd1);
        chk("fl_m1_rdata", 64'(m1_rdata), 64'(rq.pop_front()));
        tick();
        s_rvalid = 1'b0;
        chk("fl_out0_end", 64'(dut.out0_q), 64'd0);

        // stray id bits are swallowed
        s_rvalid = 1'b1; s_rid = 4'd2; m0_rready = 1'b0; m1_rready = 1'b0;
        #1;
        chk("badid_rready", 64'(s_rready), 64'd1);
        chk("badid_fwd", 64'({m0_rvalid, m1_rvalid}), 64'd0);
        tick();
        s_rvalid = 1'b0;

        // reset mid-issue
        s_arready = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h500;
        tick();
        m1_arvalid = 1'b0;
        chk("ri_valid", 64'(s_arvalid), 64'd1);
        chk("ri_out1", 64'(dut.out1_q), 64'd1);
        nrst = 1'b1;
        m1_arvalid = 1'b1;
        tick();
        chk("ri_drop", 64'(s_arvalid), 64'd0);
        chk("ri_cnt", 64'({dut.out0_q, dut.out1_q, dut.drop0_q}), 64'd0);
        chk("ri_noack", 64'(m1_arready), 64'd0);
        m1_arvalid = 1'b0;
        nrst = 1'b0;
        tick();

        chk("sb_empty", 64'(arq.size() + rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
